// File: rtl/bt_uart_dir_decoder_if.sv
// Serial line and decoded outputs between the Bluetooth UART front end and its consumer.
// master drives the RX line and observes results; slave is the decoder.
interface bt_uart_dir_decoder_if;
   logic       get;
   logic [3:0] dir;
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       frame_err;

   modport master (
      output get,
      input  dir,
      input  rx_byte,
      input  byte_valid,
      input  frame_err
   );

   modport slave (
      input  get,
      output dir,
      output rx_byte,
      output byte_valid,
      output frame_err
   );
endinterface

// File: rtl/bt_uart_dir_decoder.sv
// 8N1 UART receiver that decodes ASCII L/U/D/R/S (either case) into a one-hot direction.
// Define BT_DIR_TIMEOUT_EN to release dir to stop after TIMEOUT_CYCLES without a byte.
module bt_uart_dir_decoder #(
   parameter int CLK_HZ         = 100000000,
   parameter int BAUD           = 9600,
   parameter int CLKS_PER_BIT   = CLK_HZ / BAUD
`ifdef BT_DIR_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
   input logic                  clk,
   input logic                  rst,
   bt_uart_dir_decoder_if.slave bus
);
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   logic        get_meta_q;
   logic        get_s_q;
   state_t      state_q;
   logic [15:0] bit_cnt_q;
   logic [2:0]  bit_idx_q;
   logic [7:0]  shreg_q;
   logic [7:0]  rx_byte_q;
   logic        byte_valid_q;
   logic        frame_err_q;
   logic [3:0]  dir_q;
   logic [3:0]  dir_d;

`ifdef BT_DIR_TIMEOUT_EN
   localparam logic [25:0] IDLE_LAST = 26'(TIMEOUT_CYCLES);
   logic [25:0] idle_q;
`endif

   // Synchronizer idles high so a reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         get_meta_q <= 1'b1;
         get_s_q    <= 1'b1;
      end else begin
         get_meta_q <= bus.get;
         get_s_q    <= get_meta_q;
      end
   end

   // Setting bit 5 folds only the matching uppercase letter onto each lowercase code.
   always_comb begin
      dir_d = dir_q;
      case (shreg_q | 8'h20)
         8'h6C:   dir_d = 4'b1000;
         8'h75:   dir_d = 4'b0100;
         8'h64:   dir_d = 4'b0010;
         8'h72:   dir_d = 4'b0001;
         8'h73:   dir_d = 4'b0000;
         default: dir_d = dir_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         bit_idx_q    <= '0;
         shreg_q      <= '0;
         rx_byte_q    <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         dir_q        <= '0;
`ifdef BT_DIR_TIMEOUT_EN
         idle_q       <= '0;
`endif
      end else begin
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
`ifdef BT_DIR_TIMEOUT_EN
         if (idle_q == IDLE_LAST) begin
            dir_q <= '0;
         end else begin
            idle_q <= idle_q + 26'd1;
         end
`endif
         case (state_q)
            IDLE: begin
               if (!get_s_q) begin
                  state_q   <= START;
                  bit_cnt_q <= '0;
               end
            end
            START: begin
               if (bit_cnt_q == HALF_LAST) begin
                  bit_cnt_q <= '0;
                  bit_idx_q <= '0;
                  state_q   <= get_s_q ? IDLE : DATA;
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            DATA: begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q <= '0;
                  shreg_q   <= {get_s_q, shreg_q[7:1]};
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            STOP: begin
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_q <= '0;
                  if (get_s_q) begin
                     rx_byte_q    <= shreg_q;
                     byte_valid_q <= 1'b1;
                     dir_q        <= dir_d;
`ifdef BT_DIR_TIMEOUT_EN
                     idle_q       <= '0;
`endif
                     state_q      <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end else begin
                  bit_cnt_q <= bit_cnt_q + 16'd1;
               end
            end
            BREAK: begin
               if (get_s_q) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.dir        = dir_q;
   assign bus.rx_byte    = rx_byte_q;
   assign bus.byte_valid = byte_valid_q;
   assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_bt_uart_dir_decoder.sv
// Directed bench for bt_uart_dir_decoder at 16 clocks per bit.
// Builds with or without BT_DIR_TIMEOUT_EN (TIMEOUT_CYCLES=1000 when defined).
`timescale 1ns/1ps
module tb_bt_uart_dir_decoder;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bt_uart_dir_decoder_if bus();

   bt_uart_dir_decoder #(
      .CLK_HZ(1600000),
      .BAUD(100000)
`ifdef BT_DIR_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(1000)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;
   int bv_cnt = 0;
   int fe_cnt = 0;
   int both_cnt = 0;
   int cyc = 0;
   int bv_cyc = 0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (bus.byte_valid) begin
         bv_cnt <= bv_cnt + 1;
         bv_cyc <= cyc + 1;
      end
      if (bus.frame_err) fe_cnt <= fe_cnt + 1;
      if (bus.byte_valid && bus.frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic idle_bits(input int n);
      bus.get = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
      bus.get = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         bus.get = b[i];
         repeat (CPB) @(negedge clk);
      end
      bus.get = stop_bit;
      repeat (CPB) @(negedge clk);
      repeat (extra_low * CPB) @(negedge clk);
      bus.get = 1'b1;
      $display("frame byte=%02h stop=%0b rx_byte=%02h dir=%04b bv=%0d fe=%0d",
               b, stop_bit, bus.rx_byte, bus.dir, bv_cnt, fe_cnt);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.get = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (bus.dir !== 4'b0000) begin bad++; $display("FAIL reset_dir got=%04b exp=0000", bus.dir); end
      total++; if (bus.rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx got=%02h exp=00", bus.rx_byte); end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL reset_bv got=%b exp=0", bus.byte_valid); end
      total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", bus.frame_err); end
      rst = 1'b0;
      idle_bits(2);
   endtask

   task automatic test_left();
      int bv0 = bv_cnt;
      int fe0 = fe_cnt;
      send_frame(8'h4C, 1'b1, 0);
      total++; if (bv_cnt !== bv0 + 1) begin bad++; $display("FAIL left_bv got=%0d exp=%0d", bv_cnt - bv0, 1); end
      total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL left_fe got=%0d exp=0", fe_cnt - fe0); end
      total++; if (bus.rx_byte !== 8'h4C) begin bad++; $display("FAIL left_rx got=%02h exp=4c", bus.rx_byte); end
      total++; if (bus.dir !== 4'b1000) begin bad++; $display("FAIL left_dir got=%04b exp=1000", bus.dir); end
      idle_bits(2);
   endtask

   task automatic test_back_to_back();
      int bv0 = bv_cnt;
      send_frame(8'h72, 1'b1, 0);
      total++; if (bus.dir !== 4'b0001) begin bad++; $display("FAIL b2b_dir1 got=%04b exp=0001", bus.dir); end
      send_frame(8'h53, 1'b1, 0);
      total++; if (bv_cnt !== bv0 + 2) begin bad++; $display("FAIL b2b_bv got=%0d exp=2", bv_cnt - bv0); end
      total++; if (bus.dir !== 4'b0000) begin bad++; $display("FAIL b2b_dir2 got=%04b exp=0000", bus.dir); end
      total++; if (bus.rx_byte !== 8'h53) begin bad++; $display("FAIL b2b_rx got=%02h exp=53", bus.rx_byte); end
      idle_bits(2);
   endtask

   task automatic test_frame_err();
      int bv0 = bv_cnt;
      int fe0 = fe_cnt;
      send_frame(8'h55, 1'b0, 3);
      idle_bits(2);
      total++; if (fe_cnt !== fe0 + 1) begin bad++; $display("FAIL ferr_fe got=%0d exp=1", fe_cnt - fe0); end
      total++; if (bv_cnt !== bv0) begin bad++; $display("FAIL ferr_bv got=%0d exp=0", bv_cnt - bv0); end
      total++; if (bus.rx_byte !== 8'h53) begin bad++; $display("FAIL ferr_rx got=%02h exp=53", bus.rx_byte); end
      total++; if (bus.dir !== 4'b0000) begin bad++; $display("FAIL ferr_dir got=%04b exp=0000", bus.dir); end
      send_frame(8'h44, 1'b1, 0);
      total++; if (bus.dir !== 4'b0010) begin bad++; $display("FAIL ferr_down_dir got=%04b exp=0010", bus.dir); end
      total++; if (bus.rx_byte !== 8'h44) begin bad++; $display("FAIL ferr_down_rx got=%02h exp=44", bus.rx_byte); end
      idle_bits(2);
   endtask

   task automatic test_glitch();
      int bv0 = bv_cnt;
      int fe0 = fe_cnt;
      bus.get = 1'b0;
      repeat (5) @(negedge clk);
      idle_bits(3);
      $display("glitch 5 clks low bv=%0d fe=%0d", bv_cnt, fe_cnt);
      total++; if (bv_cnt !== bv0) begin bad++; $display("FAIL glitch_bv got=%0d exp=0", bv_cnt - bv0); end
      total++; if (fe_cnt !== fe0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", fe_cnt - fe0); end
      send_frame(8'h52, 1'b1, 0);
      total++; if (bus.dir !== 4'b0001) begin bad++; $display("FAIL glitch_r_dir got=%04b exp=0001", bus.dir); end
      idle_bits(2);
   endtask

   task automatic test_unknown();
      int bv0 = bv_cnt;
      send_frame(8'h4C, 1'b1, 0);
      send_frame(8'h58, 1'b1, 0);
      total++; if (bv_cnt !== bv0 + 2) begin bad++; $display("FAIL unk_bv got=%0d exp=2", bv_cnt - bv0); end
      total++; if (bus.rx_byte !== 8'h58) begin bad++; $display("FAIL unk_rx got=%02h exp=58", bus.rx_byte); end
      total++; if (bus.dir !== 4'b1000) begin bad++; $display("FAIL unk_dir got=%04b exp=1000", bus.dir); end
      idle_bits(2);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'h52;
      bus.get = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         bus.get = b[i];
         repeat (CPB) @(negedge clk);
      end
      rst = 1'b1;
      bus.get = 1'b1;
      #1;
      $display("reset mid-frame dir=%04b rx_byte=%02h", bus.dir, bus.rx_byte);
      total++; if (bus.dir !== 4'b0000) begin bad++; $display("FAIL rmid_dir got=%04b exp=0000", bus.dir); end
      total++; if (bus.rx_byte !== 8'h00) begin bad++; $display("FAIL rmid_rx got=%02h exp=00", bus.rx_byte); end
      total++; if (bus.byte_valid !== 1'b0) begin bad++; $display("FAIL rmid_bv got=%b exp=0", bus.byte_valid); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
      send_frame(8'h52, 1'b1, 0);
      total++; if (bus.dir !== 4'b0001) begin bad++; $display("FAIL rmid_r_dir got=%04b exp=0001", bus.dir); end
      total++; if (bus.rx_byte !== 8'h52) begin bad++; $display("FAIL rmid_r_rx got=%02h exp=52", bus.rx_byte); end
   endtask

`ifdef BT_DIR_TIMEOUT_EN
   task automatic test_timeout();
      int target;
      target = bv_cyc + 1000;
      while (cyc < target) begin
         @(negedge clk);
         #1;
      end
      total++; if (bus.dir !== 4'b0001) begin bad++; $display("FAIL tmo_before got=%04b exp=0001", bus.dir); end
      @(negedge clk);
      #1;
      total++; if (bus.dir !== 4'b0000) begin bad++; $display("FAIL tmo_after got=%04b exp=0000", bus.dir); end
      $display("timeout at cyc=%0d last_bv_cyc=%0d dir=%04b", cyc, bv_cyc, bus.dir);
   endtask
`else
   task automatic test_hold();
      repeat (300) @(negedge clk);
      $display("hold 300 clks dir=%04b", bus.dir);
      total++; if (bus.dir !== 4'b0001) begin bad++; $display("FAIL hold_dir got=%04b exp=0001", bus.dir); end
   endtask
`endif

   task automatic test_exclusive();
      total++; if (both_cnt !== 0) begin bad++; $display("FAIL exclusive got=%0d exp=0", both_cnt); end
   endtask

   initial begin
      bus.get = 1'b1;
      test_reset();
      test_left();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_unknown();
      test_reset_mid();
`ifdef BT_DIR_TIMEOUT_EN
      test_timeout();
`else
      test_hold();
`endif
      test_exclusive();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
